// File: rtl/io_stimulus_gen_if.sv
// Configuration/stimulus bus of the input-port stimulus generator.
// The master side drives enable and config; the slave side is the generator.
interface io_stimulus_gen_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    logic                      enable;
    logic                      cfg_we;
    logic [3:0]                cfg_ch;
    logic [1:0]                cfg_mode;
    logic [WIDTH-1:0]          cfg_seed;
    logic [WIDTH-1:0]          cfg_step;
    logic                      cpu_resetn;
    logic [CHANNELS*WIDTH-1:0] in_port;
    logic                      update;
    logic [15:0]               update_count;

    modport master (
        output enable, cfg_we, cfg_ch, cfg_mode, cfg_seed, cfg_step,
        input  cpu_resetn, in_port, update, update_count
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_mode, cfg_seed, cfg_step,
        output cpu_resetn, in_port, update, update_count
    );
endinterface

// File: rtl/io_stimulus_gen.sv
// Input-port stimulus generator: CPU reset hold plus CHANNELS per-port value
// sequencers that advance together every PERIOD enabled clocks.

// One channel: run-time mode, step and current value.
module io_stimulus_lane #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       wr_mode,
    input  logic [WIDTH-1:0] wr_seed,
    input  logic [WIDTH-1:0] wr_step,
    output logic [WIDTH-1:0] value
);
    typedef enum logic [1:0] {M_HOLD, M_INC, M_LFSR, M_WALK} mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] next_value;

    always_comb begin
        next_value = value;
        case (mode)
            M_HOLD: next_value = value;
            M_INC:  next_value = value + step;
            // zero is the LFSR lock-up state; escape it to 1
            M_LFSR: next_value = (value == '0) ? WIDTH'(1)
                                               : ((value >> 1) ^ (value[0] ? TAPS : '0));
            M_WALK: next_value = (value << 1) | (value >> (WIDTH-1));
            default: next_value = value;
        endcase
    end

    // a config write beats a same-edge update for this channel
    always_ff @(posedge clock) begin
        if (reset) begin
            mode  <= M_INC;
            step  <= WIDTH'(1);
            value <= INIT;
        end else if (wr) begin
            mode  <= mode_e'(wr_mode);
            step  <= wr_step;
            value <= wr_seed;
        end else if (tick) begin
            value <= next_value;
        end
    end
endmodule

module io_stimulus_gen #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 2,
    parameter int               PERIOD       = 5,
    parameter int               RESET_CYCLES = 5,
    parameter logic [WIDTH-1:0] INIT_BASE    = '0,
    parameter logic [31:0]      TAPS         = 32'h80200003
) (
    input  logic             clock,
    input  logic             reset,
    io_stimulus_gen_if.slave bus
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [WIDTH-1:0] TAPS_W = WIDTH'(TAPS);

    typedef struct packed {
        logic             we;
        logic [3:0]       ch;
        logic [1:0]       mode;
        logic [WIDTH-1:0] seed;
        logic [WIDTH-1:0] step;
    } cfg_req_t;

    cfg_req_t                         cfg;
    logic [TW-1:0]                    timer;
    logic                             tick;
    logic [RW-1:0]                    hold_cnt;
    logic                             cpu_resetn_q;
    logic                             update_q;
    logic [15:0]                      update_count_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   values;

    assign cfg  = '{we: bus.cfg_we, ch: bus.cfg_ch, mode: bus.cfg_mode,
                    seed: bus.cfg_seed, step: bus.cfg_step};
    assign tick = bus.enable && (timer == TW'(PERIOD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            timer          <= '0;
            update_q       <= 1'b0;
            update_count_q <= '0;
        end else begin
            update_q <= tick;
            if (bus.enable)
                timer <= tick ? '0 : timer + TW'(1);
            if (tick)
                update_count_q <= update_count_q + 16'd1;
        end
    end

    // cpu_resetn rises on the RESET_CYCLES-th edge after reset and the
    // saturated counter keeps it there
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt     <= '0;
            cpu_resetn_q <= 1'b0;
        end else if (hold_cnt != RW'(RESET_CYCLES)) begin
            hold_cnt     <= hold_cnt + RW'(1);
            cpu_resetn_q <= (hold_cnt == RW'(RESET_CYCLES - 1));
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        io_stimulus_lane #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS_W),
            .INIT  (INIT_BASE + WIDTH'(k))
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick),
            .wr      (cfg.we && (cfg.ch == 4'(k))),
            .wr_mode (cfg.mode),
            .wr_seed (cfg.seed),
            .wr_step (cfg.step),
            .value   (values[k])
        );
    end

    assign bus.cpu_resetn   = cpu_resetn_q;
    assign bus.in_port      = values;
    assign bus.update       = update_q;
    assign bus.update_count = update_count_q;
endmodule

// File: tb/tb_io_stimulus_gen.sv
// Directed bench for io_stimulus_gen: PERIOD=5 main instance plus a PERIOD=1 instance.
module tb_io_stimulus_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    io_stimulus_gen_if #(.WIDTH(32), .CHANNELS(2)) bus0 ();
    io_stimulus_gen_if #(.WIDTH(32), .CHANNELS(2)) bus1 ();

    io_stimulus_gen #(.WIDTH(32), .CHANNELS(2), .PERIOD(5), .RESET_CYCLES(5)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));
    io_stimulus_gen #(.WIDTH(32), .CHANNELS(2), .PERIOD(1), .RESET_CYCLES(5)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [1:0] mode,
                             input logic [31:0] seed, input logic [31:0] stp);
        bus0.cfg_we = 1'b1; bus0.cfg_ch = ch; bus0.cfg_mode = mode;
        bus0.cfg_seed = seed; bus0.cfg_step = stp;
        step();
        bus0.cfg_we = 1'b0;
    endtask

    task automatic wait_update();
        bit ok = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus0.update === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_update: no update pulse within 12 clocks"); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks += 5;
        if (bus0.cpu_resetn !== 1'b0) begin errors++; $display("FAIL reset_cpu_resetn: got %b want 0", bus0.cpu_resetn); end
        if (bus0.in_port[31:0] !== 32'd0) begin errors++; $display("FAIL reset_ch0: got %h want 0", bus0.in_port[31:0]); end
        if (bus0.in_port[63:32] !== 32'd1) begin errors++; $display("FAIL reset_ch1: got %h want 1", bus0.in_port[63:32]); end
        if (bus0.update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", bus0.update); end
        if (bus0.update_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus0.update_count); end
    endtask

    task automatic test_defaults();
        logic exp_rn, exp_up;
        reset = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step();
            exp_rn = (e >= 5);
            exp_up = (e % 5 == 0);
            checks += 2;
            if (bus0.cpu_resetn !== exp_rn) begin errors++; $display("FAIL dflt_cpu_resetn edge %0d: got %b want %b", e, bus0.cpu_resetn, exp_rn); end
            if (bus0.update !== exp_up) begin errors++; $display("FAIL dflt_update edge %0d: got %b want %b", e, bus0.update, exp_up); end
            if (exp_up) begin
                checks += 2;
                if (bus0.in_port[31:0] !== 32'(e / 5)) begin errors++; $display("FAIL dflt_ch0 edge %0d: got %h want %h", e, bus0.in_port[31:0], e / 5); end
                if (bus0.in_port[63:32] !== 32'(e / 5 + 1)) begin errors++; $display("FAIL dflt_ch1 edge %0d: got %h want %h", e, bus0.in_port[63:32], e / 5 + 1); end
            end
        end
        checks++;
        if (bus0.update_count !== 16'd3) begin errors++; $display("FAIL dflt_count: got %0d want 3", bus0.update_count); end
    endtask

    task automatic test_lfsr();
        cfg_write(4'd0, 2'd2, 32'd1, 32'd0);
        checks++;
        if (bus0.in_port[31:0] !== 32'd1) begin errors++; $display("FAIL lfsr_seed: got %h want 1", bus0.in_port[31:0]); end
        wait_update();
        checks++;
        if (bus0.in_port[31:0] !== 32'h80200003) begin errors++; $display("FAIL lfsr_tick1: got %h want 80200003", bus0.in_port[31:0]); end
        wait_update();
        checks++;
        if (bus0.in_port[31:0] !== 32'hC0300002) begin errors++; $display("FAIL lfsr_tick2: got %h want c0300002", bus0.in_port[31:0]); end
        cfg_write(4'd0, 2'd2, 32'd0, 32'd0);
        wait_update();
        checks++;
        if (bus0.in_port[31:0] !== 32'd1) begin errors++; $display("FAIL lfsr_lockup: got %h want 1", bus0.in_port[31:0]); end
    endtask

    task automatic test_walk();
        cfg_write(4'd1, 2'd3, 32'h80000000, 32'd0);
        wait_update();
        checks++;
        if (bus0.in_port[63:32] !== 32'h1) begin errors++; $display("FAIL walk_tick1: got %h want 1", bus0.in_port[63:32]); end
        wait_update();
        checks++;
        if (bus0.in_port[63:32] !== 32'h2) begin errors++; $display("FAIL walk_tick2: got %h want 2", bus0.in_port[63:32]); end
        cfg_write(4'd1, 2'd3, 32'd0, 32'd0);
        wait_update();
        checks++;
        if (bus0.in_port[63:32] !== 32'h0) begin errors++; $display("FAIL walk_zero: got %h want 0", bus0.in_port[63:32]); end
    endtask

    task automatic test_inc_hold();
        cfg_write(4'd0, 2'd1, 32'd0, 32'hFFFFFFFF);
        wait_update();
        checks++;
        if (bus0.in_port[31:0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL inc_wrap1: got %h want ffffffff", bus0.in_port[31:0]); end
        wait_update();
        checks++;
        if (bus0.in_port[31:0] !== 32'hFFFFFFFE) begin errors++; $display("FAIL inc_wrap2: got %h want fffffffe", bus0.in_port[31:0]); end
        cfg_write(4'd0, 2'd0, 32'h5A5A, 32'd7);
        for (int t = 0; t < 3; t++) begin
            wait_update();
            checks++;
            if (bus0.in_port[31:0] !== 32'h5A5A) begin errors++; $display("FAIL hold tick %0d: got %h want 5a5a", t, bus0.in_port[31:0]); end
        end
    endtask

    task automatic test_back_to_back();
        // timer is 0 after the last tick; the write edge moves it to 1
        cfg_write(4'd0, 2'd1, 32'h10, 32'd1);
        step(); step(); step();
        checks++;
        if (bus0.update !== 1'b0) begin errors++; $display("FAIL b2b_pre_update: got %b want 0", bus0.update); end
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 4'd1; bus0.cfg_mode = 2'd0;
        bus0.cfg_seed = 32'h1234; bus0.cfg_step = 32'd0;
        step();
        bus0.cfg_we = 1'b0;
        checks += 4;
        if (bus0.update !== 1'b1) begin errors++; $display("FAIL b2b_update: got %b want 1", bus0.update); end
        if (bus0.in_port[63:32] !== 32'h1234) begin errors++; $display("FAIL b2b_ch1_write: got %h want 1234", bus0.in_port[63:32]); end
        if (bus0.in_port[31:0] !== 32'h11) begin errors++; $display("FAIL b2b_ch0_step: got %h want 11", bus0.in_port[31:0]); end
        if (bus0.update_count !== 16'd15) begin errors++; $display("FAIL b2b_count: got %0d want 15", bus0.update_count); end
        cfg_write(4'd2, 2'd3, 32'hFFFF, 32'd1);
        checks += 2;
        if (bus0.in_port[31:0] !== 32'h11) begin errors++; $display("FAIL badch_ch0: got %h want 11", bus0.in_port[31:0]); end
        if (bus0.in_port[63:32] !== 32'h1234) begin errors++; $display("FAIL badch_ch1: got %h want 1234", bus0.in_port[63:32]); end
    endtask

    task automatic test_enable_freeze();
        bus0.enable = 1'b0;
        for (int e = 0; e < 7; e++) begin
            step();
            checks += 3;
            if (bus0.update !== 1'b0) begin errors++; $display("FAIL frz_update edge %0d: got %b want 0", e, bus0.update); end
            if (bus0.in_port[31:0] !== 32'h11) begin errors++; $display("FAIL frz_ch0 edge %0d: got %h want 11", e, bus0.in_port[31:0]); end
            if (bus0.update_count !== 16'd15) begin errors++; $display("FAIL frz_count edge %0d: got %0d want 15", e, bus0.update_count); end
        end
        bus0.enable = 1'b1;
        step(); step(); step();
        checks++;
        if (bus0.update !== 1'b0) begin errors++; $display("FAIL frz_resume_early: got %b want 0", bus0.update); end
        step();
        checks += 3;
        if (bus0.update !== 1'b1) begin errors++; $display("FAIL frz_resume_update: got %b want 1", bus0.update); end
        if (bus0.in_port[31:0] !== 32'h12) begin errors++; $display("FAIL frz_resume_ch0: got %h want 12", bus0.in_port[31:0]); end
        if (bus0.update_count !== 16'd16) begin errors++; $display("FAIL frz_resume_count: got %0d want 16", bus0.update_count); end
    endtask

    task automatic test_reset_mid();
        logic exp_rn;
        reset = 1'b1;
        step();
        checks += 5;
        if (bus0.cpu_resetn !== 1'b0) begin errors++; $display("FAIL mid_cpu_resetn: got %b want 0", bus0.cpu_resetn); end
        if (bus0.in_port[31:0] !== 32'd0) begin errors++; $display("FAIL mid_ch0: got %h want 0", bus0.in_port[31:0]); end
        if (bus0.in_port[63:32] !== 32'd1) begin errors++; $display("FAIL mid_ch1: got %h want 1", bus0.in_port[63:32]); end
        if (bus0.update !== 1'b0) begin errors++; $display("FAIL mid_update: got %b want 0", bus0.update); end
        if (bus0.update_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus0.update_count); end
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            exp_rn = (e == 5);
            checks++;
            if (bus0.cpu_resetn !== exp_rn) begin errors++; $display("FAIL mid_hold edge %0d: got %b want %b", e, bus0.cpu_resetn, exp_rn); end
        end
        checks += 3;
        if (bus0.update !== 1'b1) begin errors++; $display("FAIL mid_update5: got %b want 1", bus0.update); end
        if (bus0.in_port[31:0] !== 32'd1) begin errors++; $display("FAIL mid_ch0_inc: got %h want 1", bus0.in_port[31:0]); end
        if (bus0.in_port[63:32] !== 32'd2) begin errors++; $display("FAIL mid_ch1_inc: got %h want 2", bus0.in_port[63:32]); end
    endtask

    task automatic test_period1();
        reset = 1'b1;
        bus1.enable = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks += 4;
            if (bus1.update !== 1'b1) begin errors++; $display("FAIL p1_update edge %0d: got %b want 1", k, bus1.update); end
            if (bus1.update_count !== 16'(k)) begin errors++; $display("FAIL p1_count edge %0d: got %0d want %0d", k, bus1.update_count, k); end
            if (bus1.in_port[31:0] !== 32'(k)) begin errors++; $display("FAIL p1_ch0 edge %0d: got %h want %h", k, bus1.in_port[31:0], k); end
            if (bus1.in_port[63:32] !== 32'(k + 1)) begin errors++; $display("FAIL p1_ch1 edge %0d: got %h want %h", k, bus1.in_port[63:32], k + 1); end
        end
        bus1.enable = 1'b0;
        step();
        checks += 2;
        if (bus1.update !== 1'b0) begin errors++; $display("FAIL p1_disabled_update: got %b want 0", bus1.update); end
        if (bus1.update_count !== 16'd4) begin errors++; $display("FAIL p1_disabled_count: got %0d want 4", bus1.update_count); end
    endtask

    initial begin
        bus0.enable = 1'b1; bus0.cfg_we = 1'b0; bus0.cfg_ch = '0;
        bus0.cfg_mode = '0; bus0.cfg_seed = '0; bus0.cfg_step = '0;
        bus1.enable = 1'b0; bus1.cfg_we = 1'b0; bus1.cfg_ch = '0;
        bus1.cfg_mode = '0; bus1.cfg_seed = '0; bus1.cfg_step = '0;
        test_reset();
        test_defaults();
        test_lfsr();
        test_walk();
        test_inc_hold();
        test_back_to_back();
        test_enable_freeze();
        test_reset_mid();
        test_period1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
